// File: rtl/prio_encoder8to3_hs_pkg.sv
// Shared types and helpers for the sequential priority encoder and its clear-mask decoder.
package prio_encoder8to3_hs_pkg;

    localparam int unsigned NUM_REQ_DEFAULT = 8;
    localparam int unsigned IDX_W_DEFAULT   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Ascending scan so the last (highest) set bit overwrites; returns 0 for an empty vector.
    function automatic logic [4:0] highest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = i[4:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_encoder8to3_hs_if.sv
// Request/grant handshake bundle between event sources, the encoder and the index consumer.
interface prio_encoder8to3_hs_if #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDX_W   = 3
);
    logic [NUM_REQ-1:0] in;
    logic               en;
    logic               ack;
    logic [IDX_W-1:0]   out;
    logic               valid;
    logic [NUM_REQ-1:0] pend;
    logic               any;

    modport master (
        output in, en, ack,
        input  out, valid, pend, any
    );

    modport slave (
        input  in, en, ack,
        output out, valid, pend, any
    );
endinterface

// File: rtl/prio_encoder8to3_hs_onehot_dec.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
module onehot_dec #(
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned NUM_REQ = 8
) (
    input  logic [IDX_W-1:0]   i_idx,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_onehot
);
    always_comb begin
        o_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            o_onehot[i] = i_en && (i_idx == IDX_W'(i));
        end
    end
endmodule

// File: rtl/prio_encoder8to3_hs.sv
// Sticky-pending fixed-priority encoder presenting the highest pending index on a valid/ack handshake.
module prio_encoder8to3_hs
    import prio_encoder8to3_hs_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned IDX_W   = IDX_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    prio_encoder8to3_hs_if.slave  bus
);
    generate
        if (IDX_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 32) begin : g_bad_params
            $error("prio_encoder8to3_hs: NUM_REQ must be a power of two in 2..32 with IDX_W == clog2(NUM_REQ)");
        end
    endgenerate

    state_t             r_state;
    logic [IDX_W-1:0]   r_out;
    logic               r_valid;
    logic [NUM_REQ-1:0] r_pend;

    state_t             w_state_next;
    logic [IDX_W-1:0]   w_out_next;
    logic               w_valid_next;
    logic [NUM_REQ-1:0] w_pend_next;
    logic [NUM_REQ-1:0] w_cap;
    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_clr;
    logic               w_ack_take;

    assign w_cap      = bus.en ? bus.in : '0;
    assign w_cand     = r_pend | w_cap;
    assign w_ack_take = (r_state == HOLD) && bus.ack;

    onehot_dec #(
        .IDX_W   (IDX_W),
        .NUM_REQ (NUM_REQ)
    ) u_clr_dec (
        .i_idx    (r_out),
        .i_en     (w_ack_take),
        .o_onehot (w_clr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            r_valid <= w_valid_next;
            r_pend  <= w_pend_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_out_next   = r_out;
        w_valid_next = r_valid;
        // Set applied after clear so a re-request of the acked bit stays pending.
        w_pend_next  = (r_pend & ~w_clr) | w_cap;
        case (r_state)
            IDLE: begin
                if (|w_cand) begin
                    w_out_next   = IDX_W'(highest_set(32'(w_cand)));
                    w_valid_next = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.ack) begin
                    w_valid_next = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.out   = r_out;
    assign bus.valid = r_valid;
    assign bus.pend  = r_pend;
    assign bus.any   = |r_pend;

endmodule
